// File: rtl/seq_alu_datapath.sv
// ---------------------------------------------------------------------------
// seq_alu_datapath
//
// Sequential register-file ALU. One operation runs per start request:
//   IDLE -> LDY (Y <= R[rb]) -> EXEC (1 cycle for ALU ops, WIDTH cycles for
//   MUL/DIV) -> WB (done pulse, result valid) -> IDLE.
// ALU ops (ADD/SUB/AND/OR/SHR/SHL) write R[ra] on the edge ending WB.
// MUL/DIV write only the HI/LO pair, which becomes visible when WB starts.
//
// Ports
//   clk              single clock, rising edge
//   clr              synchronous active-high clear (highest priority)
//   start            begin one operation (sampled only in IDLE)
//   op               0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 MUL, 7 DIV
//   ra, rb, rc       destination, first source, second source
//   use_imm, imm     replace the Rc operand with imm
//   wr_en/addr/data  external register load (IDLE only)
//   rd_addr/rd_data  combinational register read-back
//   busy, done       busy in LDY/EXEC/WB, done in WB only
//   result           last written-back low word (held outside WB)
//   hi_out, lo_out   HI/LO registers
//   div0             last DIV had a zero divisor
// ---------------------------------------------------------------------------
module seq_alu_datapath #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [$clog2(NREGS)-1:0] ra,
  input  logic [$clog2(NREGS)-1:0] rb,
  input  logic [$clog2(NREGS)-1:0] rc,
  input  logic                     use_imm,
  input  logic [WIDTH-1:0]         imm,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         hi_out,
  output logic [WIDTH-1:0]         lo_out,
  output logic                     div0
);

  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LDY  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd7;

  // Iteration counter covers 0..WIDTH-1 exactly because WIDTH is a power of 2.
  localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [AW-1:0]    r_ra;
  logic [AW-1:0]    r_rb;
  logic [AW-1:0]    r_rc;
  logic             r_use_imm;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_y;       // operand Y; multiplier / quotient shifter in MUL/DIV
  logic [WIDTH-1:0] r_z;
  logic [WIDTH-1:0] r_acc;     // MUL partial high word / DIV partial remainder
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic             r_div0;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_regs [NREGS];

  // ------------------------------------------------------------------
  // Operand fetch and control decode
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] w_rb_val;
  logic [WIDTH-1:0] w_rc_val;
  logic [WIDTH-1:0] w_b;
  logic [SW-1:0]    w_shamt;
  logic             w_is_md;
  logic             w_is_div;
  logic             w_last;
  logic             w_ext_we;
  logic             w_wb_we;

  assign w_rb_val = (R0_ZERO && (r_rb == '0)) ? '0 : r_regs[r_rb];
  assign w_rc_val = (R0_ZERO && (r_rc == '0)) ? '0 : r_regs[r_rc];
  assign w_b      = r_use_imm ? r_imm : w_rc_val;
  assign w_shamt  = w_b[SW-1:0];
  assign w_is_md  = r_op[2] & r_op[1];
  assign w_is_div = (r_op == OP_DIV);
  assign w_last   = (r_cnt == CNT_LAST);

  // Writes outside IDLE are dropped; WB never targets R0 when it is hardwired.
  assign w_ext_we = wr_en && (r_state == S_IDLE) && !(R0_ZERO && (wr_addr == '0));
  assign w_wb_we  = (r_state == S_WB) && !w_is_md && !(R0_ZERO && (r_ra == '0));

  // ------------------------------------------------------------------
  // Single-cycle ALU
  // ------------------------------------------------------------------
  logic [WIDTH-1:0] w_alu;

  always_comb begin
    // NOTE: a default assignment up front keeps every path driven, so no latch is inferred.
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_y + w_b;
      OP_SUB:  w_alu = r_y - w_b;
      OP_AND:  w_alu = r_y & w_b;
      OP_OR:   w_alu = r_y | w_b;
      OP_SHR:  w_alu = r_y >> w_shamt;
      OP_SHL:  w_alu = r_y << w_shamt;
      default: w_alu = '0;
    endcase
  end

  // ------------------------------------------------------------------
  // MUL step: {acc, y} is the 2W-bit product register. Add B into the high
  // half when the current multiplier LSB is set, then shift right by one.
  // ------------------------------------------------------------------
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_acc_nx;
  logic [WIDTH-1:0] w_mul_y_nx;

  assign w_mul_sum    = {1'b0, r_acc} + (r_y[0] ? {1'b0, w_b} : '0);
  assign w_mul_acc_nx = w_mul_sum[WIDTH:1];
  assign w_mul_y_nx   = {w_mul_sum[0], r_y[WIDTH-1:1]};

  // ------------------------------------------------------------------
  // DIV step (restoring): shift the next dividend bit into the remainder,
  // subtract B when it fits, shift the quotient bit into y. A zero divisor
  // always "fits", so the quotient saturates to all ones and the remainder
  // ends up equal to the original Y without any special-case path.
  // ------------------------------------------------------------------
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_acc_nx;
  logic [WIDTH-1:0] w_div_y_nx;

  assign w_div_sh     = {r_acc, r_y[WIDTH-1]};
  assign w_div_ge     = (w_div_sh >= {1'b0, w_b});
  assign w_div_acc_nx = WIDTH'(w_div_ge ? (w_div_sh - {1'b0, w_b}) : w_div_sh);
  assign w_div_y_nx   = {r_y[WIDTH-2:0], w_div_ge};

  logic [WIDTH-1:0] w_md_acc_nx;
  logic [WIDTH-1:0] w_md_y_nx;

  assign w_md_acc_nx = w_is_div ? w_div_acc_nx : w_mul_acc_nx;
  assign w_md_y_nx   = w_is_div ? w_div_y_nx   : w_mul_y_nx;

  // ------------------------------------------------------------------
  // Control FSM and datapath registers
  // ------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_rc      <= '0;
      r_use_imm <= 1'b0;
      r_imm     <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_acc     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_result  <= '0;
      r_div0    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op      <= op;
            r_ra      <= ra;
            r_rb      <= rb;
            r_rc      <= rc;
            r_use_imm <= use_imm;
            r_imm     <= imm;
            r_div0    <= 1'b0;
            r_state   <= S_LDY;
          end
        end

        S_LDY: begin
          r_y     <= w_rb_val;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_EXEC;
        end

        S_EXEC: begin
          if (!w_is_md) begin
            r_z      <= w_alu;
            r_result <= w_alu;
            r_state  <= S_WB;
          end else begin
            r_acc <= w_md_acc_nx;
            r_y   <= w_md_y_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              // Commit HI/LO on entry to WB so they are valid alongside done.
              r_hi     <= w_md_acc_nx;
              r_lo     <= w_md_y_nx;
              r_z      <= w_md_y_nx;
              r_result <= w_md_y_nx;
              r_div0   <= w_is_div && (w_b == '0);
              r_state  <= S_WB;
            end
          end
        end

        S_WB: begin
          // start is deliberately not sampled here; it is seen on the next IDLE edge.
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Register file. External writes and WB writeback happen in different
  // states, so at most one write port is active per edge.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: this array is cleared on reset because software relies on all registers reading 0 after clr.
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_ext_we) begin
      r_regs[wr_addr] <= wr_data;
    end else if (w_wb_we) begin
      r_regs[r_ra] <= r_z;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign rd_data = (R0_ZERO && (rd_addr == '0)) ? '0 : r_regs[rd_addr];
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_WB);
  assign result  = r_result;
  assign hi_out  = r_hi;
  assign lo_out  = r_lo;
  assign div0    = r_div0;

endmodule

// File: tb/tb_seq_alu_datapath.sv
// ---------------------------------------------------------------------------
// tb_seq_alu_datapath
//
// Directed stimulus with hand-computed expectations. Each issued operation
// pushes its expected WB response onto a scoreboard queue; an independent
// monitor pops and compares whenever done is seen. Register contents and
// idle-state outputs are checked directly through rd_data and the outputs.
// ---------------------------------------------------------------------------
module tb_seq_alu_datapath;

  localparam int W  = 32;
  localparam int NR = 16;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] SHR = 3'd4, SHL = 3'd5, MUL = 3'd6, DIV = 3'd7;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [2:0]    op;
  logic [3:0]    ra, rb, rc;
  logic          use_imm;
  logic [W-1:0]  imm;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic [3:0]    rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy, done, div0;
  logic [W-1:0]  result, hi_out, lo_out;

  seq_alu_datapath #(.WIDTH(W), .NREGS(NR), .R0_ZERO(1'b1)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .rc      (rc),
    .use_imm (use_imm),
    .imm     (imm),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: busy_cnt counts LDY+EXEC+WB cycles, i.e. the start-to-done latency.
  always @(negedge clk) begin
    exp_t e;
    if (clr || !busy) busy_cnt = 0;
    else              busy_cnt++;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_result"},  result,        e.res);
        check({e.tag, "_hi"},      hi_out,        e.hi);
        check({e.tag, "_lo"},      lo_out,        e.lo);
        check({e.tag, "_div0"},    {31'd0, div0}, {31'd0, e.dz});
        check({e.tag, "_latency"}, W'(busy_cnt),  W'(e.lat));
      end
    end
  end

  task automatic push_exp(input string tag, input logic [W-1:0] r, input logic [W-1:0] h,
                          input logic [W-1:0] l, input logic dz, input int lat);
    exp_t e;
    e.tag = tag; e.res = r; e.hi = h; e.lo = l; e.dz = dz; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic set_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic ui, input logic [W-1:0] im);
    op = o; ra = a; rb = b; rc = c; use_imm = ui; imm = im;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while (busy && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_returns_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] a, input logic [W-1:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c, input logic ui,
                        input logic [W-1:0] im, input logic [W-1:0] e_res,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input logic e_dz, input int e_lat);
    push_exp(tag, e_res, e_hi, e_lo, e_dz, e_lat);
    @(negedge clk);
    set_op(o, a, b, c, ui, im);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_before;

    clr = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    set_op(ADD, 4'd0, 4'd0, 4'd0, 1'b0, '0);
    repeat (3) @(negedge clk);
    clr = 1'b0;

    // Reset state
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_hi",     hi_out, 32'd0);
    check("rst_lo",     lo_out, 32'd0);
    check("rst_div0",   {31'd0, div0}, 32'd0);
    check_reg("rst_r1", 4'd1, 32'd0);

    // Single-cycle ALU ops
    wr_reg(4'd2, 32'd7);
    wr_reg(4'd3, 32'd5);
    run_op("add", ADD,  4'd1, 4'd2, 4'd3, 1'b0, 32'd0,   32'd12, 32'd0, 32'd0, 1'b0, 3);
    check_reg("add_r1", 4'd1, 32'd12);
    run_op("sub", SUB,  4'd5, 4'd2, 4'd3, 1'b0, 32'd0,   32'd2,  32'd0, 32'd0, 1'b0, 3);
    check_reg("sub_r5", 4'd5, 32'd2);
    run_op("and", AND_, 4'd6, 4'd2, 4'd0, 1'b1, 32'hC,   32'd4,  32'd0, 32'd0, 1'b0, 3);
    run_op("or",  OR_,  4'd7, 4'd2, 4'd3, 1'b0, 32'd0,   32'd7,  32'd0, 32'd0, 1'b0, 3);
    run_op("shr", SHR,  4'd8, 4'd2, 4'd0, 1'b1, 32'd1,   32'd3,  32'd0, 32'd0, 1'b0, 3);
    check_reg("shr_r8", 4'd8, 32'd3);

    // MUL: 2^16 * 2^16 = 2^32 -> HI=1, LO=0; R1 untouched
    wr_reg(4'd2, 32'h0001_0000);
    wr_reg(4'd3, 32'h0001_0000);
    run_op("mul", MUL, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, 32'd0, 32'd1, 32'd0, 1'b0, W + 2);
    check_reg("mul_r1_kept", 4'd1, 32'd12);

    // DIV: 100/7 = 14 r 2, then divide by zero
    wr_reg(4'd2, 32'd100);
    wr_reg(4'd3, 32'd7);
    run_op("div", DIV, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0, 32'd14, 32'd2, 32'd14, 1'b0, W + 2);
    wr_reg(4'd3, 32'd0);
    run_op("div0", DIV, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0,
           32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF, 1'b1, W + 2);
    check_reg("div_r1_kept", 4'd1, 32'd12);

    // R0 hardwired to zero; div0 clears on the next accepted start
    wr_reg(4'd0, 32'h55);
    check_reg("r0_write_ignored", 4'd0, 32'd0);
    run_op("sub_r0", SUB, 4'd0, 4'd0, 4'd0, 1'b1, 32'd1,
           32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF, 1'b0, 3);
    check_reg("r0_wb_ignored", 4'd0, 32'd0);

    // Simultaneous external write and start: operand sees the new value
    push_exp("wr_start", 32'd23, 32'd100, 32'hFFFF_FFFF, 1'b0, 3);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'd20;
    set_op(ADD, 4'd10, 4'd9, 4'd0, 1'b1, 32'd3);
    start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    wait_idle("wr_start");
    check_reg("wr_start_r10", 4'd10, 32'd23);

    // SHL by imm 33 uses only 5 bits; start held through WB is taken once on
    // the following IDLE edge with the inputs present then; wr_en while busy dropped
    wr_reg(4'd2, 32'd1);
    push_exp("shl", 32'd2, 32'd100, 32'hFFFF_FFFF, 1'b0, 3);
    push_exp("held_add", 32'd6, 32'd100, 32'hFFFF_FFFF, 1'b0, 3);
    @(negedge clk);
    set_op(SHL, 4'd4, 4'd2, 4'd0, 1'b1, 32'd33);
    start = 1'b1;
    @(negedge clk);                             // LDY
    set_op(ADD, 4'd12, 4'd2, 4'd0, 1'b1, 32'd5);
    wr_en = 1'b1; wr_addr = 4'd11; wr_data = 32'hDEAD;
    @(negedge clk);                             // EXEC
    @(negedge clk);                             // WB
    wr_en = 1'b0;
    @(negedge clk);                             // IDLE gap
    check("held_start_idle_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);                             // LDY of held ADD
    start = 1'b0;
    wait_idle("held_add");
    check_reg("shl_r4", 4'd4, 32'd2);
    check_reg("held_add_r12", 4'd12, 32'd6);
    check_reg("busy_write_dropped", 4'd11, 32'd0);

    // Abort MUL with clr in EXEC cycle 5; a start during busy is ignored
    done_before = n_done;
    @(negedge clk);
    set_op(MUL, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0);
    start = 1'b1;
    @(negedge clk);                             // LDY
    start = 1'b0;
    @(negedge clk);                             // EXEC 1
    set_op(ADD, 4'd13, 4'd2, 4'd0, 1'b1, 32'd9);
    start = 1'b1;
    @(negedge clk);                             // EXEC 2
    start = 1'b0;
    @(negedge clk);                             // EXEC 3
    @(negedge clk);                             // EXEC 4
    @(negedge clk);                             // EXEC 5
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort_busy",   {31'd0, busy}, 32'd0);
    check("abort_hi",     hi_out, 32'd0);
    check("abort_lo",     lo_out, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", W'(n_done), W'(done_before));
    check_reg("abort_r1_cleared", 4'd1, 32'd0);
    check_reg("abort_r13_clear", 4'd13, 32'd0);

    // Recovery after abort
    wr_reg(4'd2, 32'd3);
    run_op("post_clr_add", ADD, 4'd1, 4'd2, 4'd0, 1'b1, 32'd4, 32'd7, 32'd0, 32'd0, 1'b0, 3);
    check_reg("post_clr_r1", 4'd1, 32'd7);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", W'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
